// File: rtl/reg_bank_pkg.sv
// Shared types and sizing helpers for the flat register bank and its clear sequencer.
package reg_bank_pkg;

   localparam int unsigned default_width = 32;
   localparam int unsigned default_depth = 32;

   typedef enum logic {
      CLR_IDLE,
      CLR_ACTIVE
   } clr_state_t;

   // A one-entry bank still needs a 1-bit address.
   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_flat_if.sv
// Write, clear, read and flattened-array signals of the register bank.
interface reg_bank_flat_if #(
   parameter int unsigned mem_width = reg_bank_pkg::default_width,
   parameter int unsigned mem_depth = reg_bank_pkg::default_depth
);
   localparam int unsigned AW = reg_bank_pkg::addr_w(mem_depth);

   logic                           we;
   logic [AW-1:0]                  waddr;
   logic [mem_width-1:0]           wdata;
   logic                           wr_drop;
   logic                           clr_req;
   logic                           busy;
   logic [AW-1:0]                  rd_addr_a;
   logic [AW-1:0]                  rd_addr_b;
   logic [mem_width-1:0]           rd_data_a;
   logic [mem_width-1:0]           rd_data_b;
   logic [mem_width*mem_depth-1:0] flat_out;

   modport master (
      output we, waddr, wdata, clr_req, rd_addr_a, rd_addr_b,
      input  wr_drop, busy, rd_data_a, rd_data_b, flat_out
   );

   modport slave (
      input  we, waddr, wdata, clr_req, rd_addr_a, rd_addr_b,
      output wr_drop, busy, rd_data_a, rd_data_b, flat_out
   );

endinterface

// File: rtl/reg_bank_flat_clear_seq.sv
// Clear sequencer: walks the array one entry per cycle, zeroing it without a reset.
module clear_seq
   import reg_bank_pkg::*;
#(
   parameter int unsigned mem_depth = default_depth,
   localparam int unsigned AW = addr_w(mem_depth)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr_req,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx
);

   localparam logic [AW-1:0] last_idx = AW'(mem_depth - 1);

   clr_state_t state;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLR_IDLE;
         busy    <= 1'b0;
         clr_idx <= '0;
      end else begin
         case (state)
            CLR_IDLE: begin
               if (clr_req) begin
                  state   <= CLR_ACTIVE;
                  busy    <= 1'b1;
                  clr_idx <= '0;
               end
            end
            CLR_ACTIVE: begin
               if (clr_idx == last_idx) begin
                  state   <= CLR_IDLE;
                  busy    <= 1'b0;
                  clr_idx <= '0;
               end else begin
                  clr_idx <= clr_idx + AW'(1);
               end
            end
            default: begin
               state <= CLR_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_en = (state == CLR_ACTIVE);

endmodule

// File: rtl/reg_bank_flat.sv
// Register-based storage array with one write port, two registered read ports,
// a flattened view of every entry, and an in-band clear sequencer.
module reg_bank_flat
   import reg_bank_pkg::*;
#(
   parameter int unsigned mem_width  = default_width,
   parameter int unsigned mem_depth  = default_depth,
   parameter bit          ZERO_ENTRY = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   reg_bank_flat_if.slave bus
);

   localparam int unsigned   AW        = addr_w(mem_depth);
   localparam logic [AW:0]   depth_lim = (AW+1)'(mem_depth);

   logic [mem_width-1:0] mem [mem_depth];
   logic                 clr_en;
   logic [AW-1:0]        clr_idx;
   logic                 busy;
   logic                 zero_hit;
   logic                 wr_accept;

   clear_seq #(.mem_depth(mem_depth)) u_clear_seq (
      .clk     (clk),
      .reset   (reset),
      .clr_req (bus.clr_req),
      .busy    (busy),
      .clr_en  (clr_en),
      .clr_idx (clr_idx)
   );

   assign bus.busy = busy;

   function automatic logic in_range(input logic [AW-1:0] addr);
      return {1'b0, addr} < depth_lim;
   endfunction

   // Writes lose to an active clear and to a clear request being accepted this edge.
   assign zero_hit  = ZERO_ENTRY && (bus.waddr == '0);
   assign wr_accept = bus.we && !clr_en && !bus.clr_req && in_range(bus.waddr) && !zero_hit;

   function automatic logic [mem_width-1:0] read_port(input logic [AW-1:0] addr);
      if (wr_accept && (bus.waddr == addr)) return bus.wdata;
      else if (!in_range(addr))             return '0;
      else if (ZERO_ENTRY && (addr == '0))  return '0;
      else                                  return mem[addr];
   endfunction

   // NOTE: storage is plain flops (it must all appear on flat_out), so resetting every entry is legal here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(mem_depth); i++) mem[i] <= '0;
         bus.rd_data_a <= '0;
         bus.rd_data_b <= '0;
         bus.wr_drop   <= 1'b0;
      end else begin
         bus.wr_drop   <= bus.we && !wr_accept;
         bus.rd_data_a <= read_port(bus.rd_addr_a);
         bus.rd_data_b <= read_port(bus.rd_addr_b);
         if (clr_en) begin
            mem[clr_idx] <= '0;
         end else if (wr_accept) begin
            mem[bus.waddr] <= bus.wdata;
         end
      end
   end

   for (genvar gi = 0; gi < int'(mem_depth); gi++) begin : g_flat
      assign bus.flat_out[gi*mem_width +: mem_width] = mem[gi];
   end

endmodule

// File: tb/tb_reg_bank_flat.sv
// Randomized and directed bench for reg_bank_flat against a cycle-level array model.
module tb_reg_bank_flat;
   import reg_bank_pkg::*;

   localparam int W = 32;
   localparam int D = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   reg_bank_flat_if #(.mem_width(W), .mem_depth(D)) bus ();

   reg_bank_flat #(.mem_width(W), .mem_depth(D), .ZERO_ENTRY(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: array of words, a pending-clear position (-1 when idle), and expected registered outputs.
   logic [W-1:0] m_mem [D];
   int           clear_pos;
   logic [W-1:0] e_rd_a;
   logic [W-1:0] e_rd_b;
   logic         e_drop;

   function automatic void model_reset();
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      clear_pos = -1;
      e_rd_a    = '0;
      e_rd_b    = '0;
      e_drop    = 1'b0;
   endfunction

   function automatic void model_edge();
      int wa;
      int ra;
      int rb;
      bit acc;
      wa  = int'(bus.waddr);
      ra  = int'(bus.rd_addr_a);
      rb  = int'(bus.rd_addr_b);
      acc = bus.we && (clear_pos < 0) && !bus.clr_req && (wa != 0) && (wa < D);
      e_drop = bus.we && !acc;
      e_rd_a = (acc && wa == ra) ? bus.wdata : ((ra < D && ra != 0) ? m_mem[ra] : '0);
      e_rd_b = (acc && wa == rb) ? bus.wdata : ((rb < D && rb != 0) ? m_mem[rb] : '0);
      if (clear_pos >= 0) begin
         m_mem[clear_pos] = '0;
         clear_pos++;
         if (clear_pos == D) clear_pos = -1;
      end else if (bus.clr_req) begin
         clear_pos = 0;
      end
      if (acc) m_mem[wa] = bus.wdata;
   endfunction

   function automatic logic [W*D-1:0] model_flat();
      logic [W*D-1:0] f;
      for (int i = 0; i < D; i++) f[i*W +: W] = m_mem[i];
      return f;
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.we      = 1'b0;
      bus.clr_req = 1'b0;
   endtask

   task automatic fill();
      for (int i = 1; i < D; i++) begin
         bus.we    = 1'b1;
         bus.waddr = 5'(i);
         bus.wdata = 32'(i + 1);
         tick();
      end
      set_idle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.flat_out !== '0) begin
         failures++;
         $display("FAIL reset_flat: got %h expected 0", bus.flat_out);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctl: busy=%b wr_drop=%b expected 0/0", bus.busy, bus.wr_drop);
      end
      checks++;
      if (bus.rd_data_a !== '0 || bus.rd_data_b !== '0) begin
         failures++;
         $display("FAIL reset_rd: got %h/%h expected 0/0", bus.rd_data_a, bus.rd_data_b);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic_write();
      bus.we    = 1'b1;
      bus.waddr = 5'd5;
      bus.wdata = 32'hDEADBEEF;
      tick();
      set_idle();
      checks++;
      if (bus.flat_out[191:160] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_flat: got %h expected deadbeef", bus.flat_out[191:160]);
      end
      bus.rd_addr_a = 5'd5;
      tick();
      checks++;
      if (bus.rd_data_a !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_read: got %h expected deadbeef", bus.rd_data_a);
      end
   endtask

   task automatic test_bypass();
      bus.we        = 1'b1;
      bus.waddr     = 5'd7;
      bus.wdata     = 32'h12345678;
      bus.rd_addr_b = 5'd7;
      bus.rd_addr_a = 5'd6;
      tick();
      set_idle();
      checks++;
      if (bus.rd_data_b !== 32'h12345678) begin
         failures++;
         $display("FAIL bypass_b: got %h expected 12345678", bus.rd_data_b);
      end
      checks++;
      if (bus.rd_data_a !== e_rd_a) begin
         failures++;
         $display("FAIL bypass_a_other: got %h expected %h", bus.rd_data_a, e_rd_a);
      end
   endtask

   task automatic test_zero_entry();
      bus.we        = 1'b1;
      bus.waddr     = 5'd0;
      bus.wdata     = 32'hFFFFFFFF;
      bus.rd_addr_a = 5'd0;
      tick();
      set_idle();
      checks++;
      if (bus.wr_drop !== 1'b1) begin
         failures++;
         $display("FAIL zero_drop: got %b expected 1", bus.wr_drop);
      end
      checks++;
      if (bus.flat_out[31:0] !== 32'h0 || bus.rd_data_a !== 32'h0) begin
         failures++;
         $display("FAIL zero_entry: flat=%h rd=%h expected 0/0", bus.flat_out[31:0], bus.rd_data_a);
      end
      tick();
      checks++;
      if (bus.wr_drop !== 1'b0 || bus.rd_data_a !== 32'h0) begin
         failures++;
         $display("FAIL zero_after: drop=%b rd=%h expected 0/0", bus.wr_drop, bus.rd_data_a);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         bus.we        = 1'($urandom_range(0, 1));
         bus.waddr     = 5'($urandom_range(0, D - 1));
         bus.wdata     = $urandom;
         bus.rd_addr_a = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, D - 1));
         bus.rd_addr_b = 5'($urandom_range(0, D - 1));
         bus.clr_req   = ($urandom_range(0, 79) == 0);
         tick();
         checks++;
         if (bus.rd_data_a !== e_rd_a || bus.rd_data_b !== e_rd_b) begin
            failures++;
            $display("FAIL rand_rd[%0d]: got %h/%h expected %h/%h", n, bus.rd_data_a, bus.rd_data_b, e_rd_a, e_rd_b);
         end
         checks++;
         if (bus.wr_drop !== e_drop || bus.busy !== (clear_pos >= 0)) begin
            failures++;
            $display("FAIL rand_ctl[%0d]: drop=%b busy=%b expected %b/%b", n, bus.wr_drop, bus.busy, e_drop, clear_pos >= 0);
         end
         checks++;
         if (bus.flat_out !== model_flat()) begin
            failures++;
            $display("FAIL rand_flat[%0d]: mismatch in array image", n);
         end
      end
      set_idle();
      while (clear_pos >= 0) tick();
   endtask

   task automatic test_clear();
      int k;
      fill();
      bus.clr_req = 1'b1;
      bus.we      = 1'b1;
      bus.waddr   = 5'd4;
      bus.wdata   = 32'hA5A5A5A5;
      tick();
      set_idle();
      checks++;
      if (bus.wr_drop !== 1'b1 || bus.busy !== 1'b1 || bus.flat_out[159:128] !== 32'd5) begin
         failures++;
         $display("FAIL clr_start: drop=%b busy=%b e4=%h expected 1/1/5", bus.wr_drop, bus.busy, bus.flat_out[159:128]);
      end
      bus.rd_addr_a = 5'd20;
      k = 0;
      while (bus.busy === 1'b1 && k < 40) begin
         if (k == 4) begin
            checks++;
            if (bus.wr_drop !== 1'b1 || bus.flat_out[319:288] !== 32'd10) begin
               failures++;
               $display("FAIL clr_write_drop: drop=%b e9=%h expected 1/a", bus.wr_drop, bus.flat_out[319:288]);
            end
         end
         if (k == 11) begin
            checks++;
            if (bus.rd_data_a !== 32'd21) begin
               failures++;
               $display("FAIL clr_read_old: got %h expected 15", bus.rd_data_a);
            end
         end
         if (k == 26) begin
            checks++;
            if (bus.rd_data_a !== 32'd0) begin
               failures++;
               $display("FAIL clr_read_new: got %h expected 0", bus.rd_data_a);
            end
         end
         bus.we    = (k == 3);
         bus.waddr = 5'd9;
         bus.wdata = 32'h0BAD0BAD;
         k++;
         tick();
      end
      set_idle();
      checks++;
      if (k !== 32) begin
         failures++;
         $display("FAIL clr_busy_len: got %0d expected 32", k);
      end
      checks++;
      if (bus.flat_out !== '0 || bus.flat_out !== model_flat()) begin
         failures++;
         $display("FAIL clr_done_flat: array not zero when busy fell");
      end
   endtask

   task automatic test_reset_mid_clear();
      logic [W-1:0] d;
      fill();
      bus.clr_req = 1'b1;
      tick();
      set_idle();
      repeat (12) tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.flat_out[415:384] !== 32'd13) begin
         failures++;
         $display("FAIL midclr_pre: busy=%b e12=%h expected 1/d", bus.busy, bus.flat_out[415:384]);
      end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      checks++;
      if (bus.busy !== 1'b0 || bus.flat_out !== '0) begin
         failures++;
         $display("FAIL midclr_reset: busy=%b flat_nonzero=%b expected 0/0", bus.busy, bus.flat_out != '0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      d = $urandom;
      bus.we        = 1'b1;
      bus.waddr     = 5'd3;
      bus.wdata     = d;
      bus.rd_addr_a = 5'd3;
      tick();
      set_idle();
      checks++;
      if (bus.flat_out[127:96] !== d || bus.rd_data_a !== d || bus.wr_drop !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_write: e3=%h rd=%h drop=%b expected %h/%h/0", bus.flat_out[127:96], bus.rd_data_a, bus.wr_drop, d, d);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_busy: got %b expected 0", bus.busy);
      end
   endtask

   initial begin
      bus.we        = 1'b0;
      bus.waddr     = '0;
      bus.wdata     = '0;
      bus.clr_req   = 1'b0;
      bus.rd_addr_a = '0;
      bus.rd_addr_b = '0;
      test_reset();
      test_basic_write();
      test_bypass();
      test_zero_entry();
      test_random();
      test_clear();
      test_reset_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_bank_flat.md
Name: reg_bank_flat

Overview:
Clocked storage array of mem_depth entries, each mem_width bits wide, with one write port and two registered read ports. It exports the entire array as one flattened bus. That bus drives the downstream parametric read-select muxes (operand/debug selection) in the RV32I pipeline. A built-in clear sequencer can zero the array on request without a reset.

Parameters:
mem_width, 32, bits per entry
mem_depth, 32, number of entries; address width AW = $clog2(mem_depth)
ZERO_ENTRY, 1, when 1, entry 0 is hardwired to zero and writes to it are discarded

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
we  input  1  write request
waddr  input  AW  write address
wdata  input  mem_width  write data
wr_drop  output  1  one-cycle pulse: write request was discarded
clr_req  input  1  start array clear (level sampled in IDLE)
busy  output  1  high while clear sequencer is active
rd_addr_a  input  AW  read port A address
rd_addr_b  input  AW  read port B address
rd_data_a  output  mem_width  registered read data A
rd_data_b  output  mem_width  registered read data B
flat_out  output  mem_width*mem_depth  all entries; entry i occupies bits [(i+1)*mem_width-1 : i*mem_width]

Behaviour:
- Reset (asynchronous, active-high):
  - every entry is 0; rd_data_a/b = 0; busy = 0; wr_drop = 0; FSM = IDLE; clear index = 0.
- Write acceptance:
  - A write is accepted at a clk edge when we=1, FSM=IDLE, clr_req=0, and not (ZERO_ENTRY=1 and waddr=0).
  - An accepted write updates the entry at that edge.
  - flat_out shows the new value from the same edge. flat_out is driven directly from the storage registers and has no extra delay.
- Discarded writes:
  - Discarded when we=1 and the FSM is in CLEAR, clr_req is asserted in IDLE, or waddr=0 with ZERO_ENTRY=1.
  - wr_drop is registered and is 1 in the cycle after the discarded request.
- waddr >= mem_depth (non-power-of-2 depth): write discarded, wr_drop pulses.
- Read ports:
  - Latency 1 cycle: rd_data_x at edge n = entry[rd_addr_x] sampled at edge n.
  - Write-first bypass: if an accepted write in the same cycle targets rd_addr_x, rd_data_x takes wdata.
  - rd_addr_x >= mem_depth returns 0.
  - Entry 0 reads 0 when ZERO_ENTRY=1.
- Clear sequencer FSM (states IDLE, CLEAR):
  - IDLE -> CLEAR when clr_req=1 at a clk edge. busy goes 1 from that edge, and the clear index is loaded with 0.
  - In CLEAR, one entry per cycle: entry[idx] is set to 0 and idx increments. The entry is zeroed at the edge where idx points to it.
  - CLEAR -> IDLE at the edge that clears idx = mem_depth-1. busy falls at that same edge.
  - Total busy time is mem_depth cycles.
  - clr_req asserted while in CLEAR is ignored; there is no restart.
  - If clr_req is still high on return to IDLE, a new clear starts at the next edge.
  - Reads remain live during CLEAR: they return 0 for entries already cleared and the old value for entries not yet cleared.
- Reset asserted mid-clear: immediate return to IDLE with all entries 0; busy = 0 asynchronously.
- Storage is registers, not inferred RAM, because every entry must be visible on flat_out at all times.

Decomposition:
- Shared package reg_bank_pkg contains:
  - clr_state_t enum {CLR_IDLE, CLR_ACTIVE};
  - localparam function for address width;
  - default width/depth constants used by the pipeline.
- One sub-module: clear_seq. It holds the FSM, index counter and busy output, and emits clr_en and clr_idx to the array.
- Storage array, read ports, bypass and write-gating stay in reg_bank_flat.

Test Plan:
- Reset, then write 0xDEADBEEF to entry 5:
  - flat_out[191:160] = 0xDEADBEEF the cycle after the write;
  - rd_addr_a=5 then gives rd_data_a = 0xDEADBEEF one cycle later.
- Same-cycle write 0x12345678 to entry 7 with rd_addr_b=7 -> rd_data_b = 0x12345678 at that edge (bypass); rd_data_a on entry 6 is unaffected.
- With ZERO_ENTRY=1, write 0xFFFFFFFF to entry 0 -> wr_drop pulses 1 cycle; flat_out[31:0] stays 0; rd_data reads 0.
- Fill all 32 entries with their index+1, then pulse clr_req:
  - busy is high for exactly 32 cycles;
  - a read of entry 20 at clear cycle 10 returns 21, and at cycle 25 returns 0;
  - flat_out is all-zero when busy falls.
- Write issued during CLEAR and in the clr_req cycle -> wr_drop=1 for each; array contents unchanged.
- Assert reset at clear cycle 12 with entries 12-31 still nonzero -> busy=0 immediately; all entries 0; after reset, a write to entry 3 works normally.
